// File: rtl/cbus_sram_responder_if.sv
// Cache-bus types and the request/response interface between an initiator
// (e.g. the data cache) and a memory-side responder.
package cbus_pkg;
  // len encodes beats-1 and is always 2^k-1, so it doubles as a wrap mask.
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } cbus_state_t;
endpackage

// Handshake: the initiator raises creq.valid with all request fields stable;
// the responder accepts it in IDLE on the next edge. Afterwards the responder
// drives cresp.ready for exactly one beat per cycle, cresp.last on the final
// beat, and the initiator advances write data/strobe after every ready.
interface cbus_sram_responder_if;
  cbus_pkg::cbus_req_t  creq;
  cbus_pkg::cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_sram_responder.sv
// Cache-bus responder backed by a word-addressed SRAM. Serves wrapping
// (critical-word-first) read/write bursts after a fixed first-beat latency.
module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  cbus_sram_responder_if.slave   cbus,
  output logic                   busy,
  output cbus_state_t            dbg_state_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [31:0] mem [MEM_WORDS];

  cbus_state_t      state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [3:0]       beat_q, beat_d;
  logic [3:0]       len_q, len_d;
  logic             wr_q, wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] len_mask;
  logic [IDX_W-1:0] beat_idx;

  // Request bits this responder never looks at (byte offset, aliased high
  // address bits, size) are collected here so they are visibly ignored.
  logic unused_req_bits;
  assign unused_req_bits = ^{cbus.creq.size, cbus.creq.addr[31:2+IDX_W],
                             cbus.creq.addr[1:0]};

  // Wrap the low bits of the start index inside the (len+1)-aligned block.
  assign len_mask = IDX_W'(len_q);
  assign beat_idx = (idx_q & ~len_mask) | ((idx_q + IDX_W'(beat_q)) & len_mask);

  // State and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: accept in IDLE, count latency, step beats, one DONE cycle.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    len_d   = len_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (cbus.creq.valid) begin
          idx_d   = cbus.creq.addr[2 +: IDX_W];
          wr_d    = cbus.creq.is_write;
          len_d   = cbus.creq.len;
          beat_d  = '0;
          lat_d   = '0;
          state_d = (LATENCY == 0) ? ST_BURST : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(LATENCY - 1)) state_d = ST_BURST;
        else                              lat_d   = lat_q + 1'b1;
      end
      ST_BURST: begin
        if (beat_q == len_q) state_d = ST_DONE;
        else                 beat_d  = beat_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the current state; data only on read beats.
  always_comb begin
    cbus.cresp = '0;
    if (state_q == ST_BURST) begin
      cbus.cresp.ready = 1'b1;
      cbus.cresp.last  = (beat_q == len_q);
      if (!wr_q) cbus.cresp.data = mem[beat_idx];
    end
    busy        = (state_q != ST_IDLE);
    dbg_state_o = state_q;
  end

  // Write beats commit the strobed lanes at the edge ending the beat; a reset
  // on that edge aborts the beat instead.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_BURST && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (cbus.creq.strobe[i]) mem[beat_idx][8*i +: 8] <= cbus.creq.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder: a LATENCY=2 and a LATENCY=0 instance.
module tb_cbus_sram_responder;
  import cbus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbus_sram_responder_if if2 ();
  cbus_sram_responder_if if0 ();
  logic        busy2, busy0;
  cbus_state_t st2, st0;

  cbus_sram_responder #(.MEM_WORDS(4096), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .cbus(if2.slave), .busy(busy2), .dbg_state_o(st2));
  cbus_sram_responder #(.MEM_WORDS(4096), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .cbus(if0.slave), .busy(busy0), .dbg_state_o(st0));

  // Request is routed to the selected instance; the other sees an idle bus.
  bit        sel;
  cbus_req_t cur_req;
  assign if2.creq = sel ? '0 : cur_req;
  assign if0.creq = sel ? cur_req : '0;

  logic        o_ready, o_last, o_busy;
  logic [31:0] o_data;
  cbus_state_t o_state;
  assign o_ready = sel ? if0.cresp.ready : if2.cresp.ready;
  assign o_last  = sel ? if0.cresp.last  : if2.cresp.last;
  assign o_data  = sel ? if0.cresp.data  : if2.cresp.data;
  assign o_busy  = sel ? busy0 : busy2;
  assign o_state = sel ? st0 : st2;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wdata_a [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".ready"}, 32'(o_ready), 32'd0);
    chk({name, ".last"},  32'(o_last),  32'd0);
    chk({name, ".data"},  o_data,       32'd0);
    chk({name, ".busy"},  32'(o_busy),  32'd0);
    chk({name, ".state"}, 32'(o_state), 32'(ST_IDLE));
  endtask

  // One full transaction; write data from wdata_a, read expectations from exp_q.
  task automatic do_txn(input bit z, input bit w, input logic [31:0] addr,
                        input logic [3:0] len, input logic [3:0] strb);
    int cyc;
    int lat;
    logic [31:0] e;
    lat = z ? 0 : 2;
    sel = z;
    @(negedge clk);
    cur_req = '0;
    cur_req.valid    = 1'b1;
    cur_req.is_write = w;
    cur_req.size     = 2'd2;
    cur_req.addr     = addr;
    cur_req.strobe   = strb;
    cur_req.data     = wdata_a[0];
    cur_req.len      = len;
    @(negedge clk);
    cur_req.valid = 1'b0;
    cyc = 1;
    while (!o_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_beat_latency", 32'(cyc), 32'(1 + lat));
    if (!o_ready) return;
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0) @(negedge clk);
      cur_req.data = wdata_a[b];
      chk("beat.ready", 32'(o_ready), 32'd1);
      chk("beat.last",  32'(o_last),  32'(b == int'(len)));
      if (w) e = 32'd0;
      else if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 32'hxxxx_xxxx;
      chk("beat.data", o_data, e);
    end
    @(negedge clk);
    chk("done.state", 32'(o_state), 32'(ST_DONE));
    chk("done.ready", 32'(o_ready), 32'd0);
    chk("done.busy",  32'(o_busy),  32'd1);
    @(negedge clk);
    chk("after.state", 32'(o_state), 32'(ST_IDLE));
    chk("after.busy",  32'(o_busy),  32'd0);
  endtask

  typedef struct {
    bit          z;
    bit          w;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cyc;
    // Single-beat vectors: writes, strobed writes, aliasing, zero strobe.
    vecs[0]  = '{0, 1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{0, 0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{0, 1, 32'h0000_0040, 4'hF, 32'h1122_3344, 32'h0};
    vecs[3]  = '{0, 1, 32'h0000_0040, 4'h4, 32'h00AA_0000, 32'h0};
    vecs[4]  = '{0, 0, 32'h0000_0040, 4'hF, 32'h0,         32'h11AA_3344};
    vecs[5]  = '{0, 1, 32'h0000_4000, 4'hF, 32'h0000_005A, 32'h0};
    vecs[6]  = '{0, 0, 32'h0000_0000, 4'hF, 32'h0,         32'h0000_005A};
    vecs[7]  = '{0, 1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{0, 0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1, 1, 32'h0000_0080, 4'hF, 32'h1234_5678, 32'h0};
    vecs[10] = '{1, 1, 32'h0000_0084, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{1, 0, 32'h0000_0080, 4'hF, 32'h0,         32'h1234_5678};

    // Clock/reset.
    sel = 1'b0;
    cur_req = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sel = 1'b0; chk_idle("reset_lat2");
    sel = 1'b1; chk_idle("reset_lat0");

    // Table-driven single-beat transactions.
    foreach (vecs[i]) begin
      wdata_a[0] = vecs[i].wdata;
      if (!vecs[i].w) exp_q.push_back(vecs[i].exp);
      do_txn(vecs[i].z, vecs[i].w, vecs[i].addr, MLEN1, vecs[i].strb);
    end

    // Wrapping read: preload words 8..11 with A0..A3, read from word 10.
    for (int i = 0; i < 4; i++) wdata_a[i] = 32'hA0 + 32'(i);
    do_txn(0, 1, 32'h0000_0020, MLEN4, 4'hF);
    exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    do_txn(0, 0, 32'h0000_0028, MLEN4, 4'hF);

    // MLEN16 wrap: fill words 64..79 with B0+i, read from word 79.
    for (int i = 0; i < 16; i++) wdata_a[i] = 32'hB0 + 32'(i);
    do_txn(0, 1, 32'h0000_0100, MLEN16, 4'hF);
    exp_q.push_back(32'hBF);
    for (int i = 0; i < 15; i++) exp_q.push_back(32'hB0 + 32'(i));
    do_txn(0, 0, 32'h0000_013C, MLEN16, 4'hF);

    // Zero latency, valid held through DONE: next accept only after DONE.
    sel = 1'b1;
    @(negedge clk);
    cur_req = '0;
    cur_req.valid = 1'b1;
    cur_req.addr  = 32'h0000_0080;
    cur_req.len   = MLEN1;
    @(negedge clk);
    chk("b2b.first.ready", 32'(o_ready), 32'd1);
    chk("b2b.first.last",  32'(o_last),  32'd1);
    chk("b2b.first.data",  o_data,       32'h1234_5678);
    @(negedge clk);
    chk("b2b.done.state", 32'(o_state), 32'(ST_DONE));
    chk("b2b.done.ready", 32'(o_ready), 32'd0);
    cur_req.addr = 32'h0000_0084;
    @(negedge clk);
    chk("b2b.gap.state", 32'(o_state), 32'(ST_IDLE));
    chk("b2b.gap.ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    cur_req.valid = 1'b0;
    chk("b2b.second.ready", 32'(o_ready), 32'd1);
    chk("b2b.second.last",  32'(o_last),  32'd1);
    chk("b2b.second.data",  o_data,       32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    chk_idle("b2b.end");

    // Reset during the second beat of an MLEN4 read.
    sel = 1'b0;
    @(negedge clk);
    cur_req = '0;
    cur_req.valid = 1'b1;
    cur_req.addr  = 32'h0000_0020;
    cur_req.len   = MLEN4;
    @(negedge clk);
    cur_req.valid = 1'b0;
    cyc = 1;
    while (!o_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst.first_beat_latency", 32'(cyc), 32'd3);
    chk("rst.beat0.data", o_data, 32'hA0);
    @(negedge clk);
    chk("rst.beat1.data", o_data, 32'hA1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("rst.abort");
    @(negedge clk);
    chk("rst.quiet.ready", 32'(o_ready), 32'd0);
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
    do_txn(0, 0, 32'h0000_0020, MLEN4, 4'hF);

    chk("exp_q.drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cbus_sram_responder.md
Name: cbus_sram_responder

Overview:
- Responder end of the cache bus (cbus). It accepts `cbus_req_t` from an initiator such as the data cache and answers with `cbus_resp_t` beats out of an internal word-addressed SRAM array.
- It serves single-beat writes and multi-beat wrapping (critical-word-first) read and write bursts, with a configurable first-beat latency.
- It is the memory-side model behind the cache in simulation and in small FPGA builds.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the array; must be a power of two; index = addr[2 +: $clog2(MEM_WORDS)], so higher address bits alias.
- LATENCY, 2, idle cycles between request acceptance and the first ready beat; 0 is legal.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- creq  input  cbus_req_t  request: valid, is_write, size, addr, strobe, data, len.
- cresp  output  cbus_resp_t  response: ready, last, data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): state becomes IDLE; cresp = '0; busy = 0; latency and beat counters clear. SRAM contents are not cleared by reset.
- A reset asserted mid-burst aborts the burst. No further ready is driven, and write beats already committed stay committed.
- Beat count is len+1: MLEN1 = 1 beat, MLEN2 = 2, MLEN4 = 4, MLEN8 = 8, MLEN16 = 16.
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE:
  - If creq.valid, latch addr, is_write and len, clear the beat counter, and go to WAIT.
  - If LATENCY = 0, go directly to BURST instead.
  - Acceptance occurs in cycle T.
- WAIT:
  - Count LATENCY cycles, then go to BURST.
  - creq.valid and all other request fields are ignored while waiting.
- BURST:
  - Exactly one beat per cycle, ready = 1 each cycle; the first beat is at cycle T+1+LATENCY.
  - Beat address: word index = base_index with its low $clog2(len+1) bits replaced by (addr_word_low + beat) mod (len+1). This wraps inside the len+1-aligned block; for example, start word 2 of a 4-beat burst gives the order 2, 3, 0, 1.
  - Read beat: cresp.data = mem[beat index], a full 32-bit word. The size field does not mask read data; lane extraction belongs to the initiator.
  - Write beat: the byte lanes enabled by the live creq.strobe are written from the live creq.data at the clock edge ending the beat. The initiator updates data/strobe after each ready. cresp.data = 0 during write beats.
  - last = 1 together with ready on the final beat (beat counter == len), then go to DONE.
- DONE:
  - Lasts one cycle with cresp = '0; creq.valid is ignored (the initiator drops valid this cycle), then go to IDLE.
  - The minimum gap between the last beat and the next acceptance is therefore 2 cycles.
- cresp.ready and cresp.last are 0 outside BURST.
- cresp.data is 0 outside read beats.
- A read beat that follows an earlier write to the same word returns the written value, since the write committed on the earlier edge.
- Request fields that change after acceptance (other than write data/strobe) have no effect until the next acceptance.
- A write with strobe == 0 still completes all its beats with ready/last and modifies no memory.

Test Plan:
- Single write, then read back:
  - Write addr 0x0000_0010, len MLEN1, strobe 4'b1111, data 0xDEADBEEF, LATENCY 2: accepted at T, ready+last at T+3, DONE at T+4.
  - Read of 0x10 with MLEN1 then returns 0xDEADBEEF with ready+last on one beat.
- Wrapping read burst:
  - Preload words 0x20..0x2C = 0xA0, 0xA1, 0xA2, 0xA3; read addr 0x28, len MLEN4.
  - Beats at T+3..T+6 carry data 0xA2, 0xA3, 0xA0, 0xA1; last only at T+6.
- Partial strobe:
  - Word 0x40 = 0x11223344; write strobe 4'b0100, data 0x00AA0000.
  - Readback = 0x11AA3344.
- Zero latency with back-to-back requests:
  - LATENCY 0: first ready at T+1; valid is held high through DONE.
  - The next acceptance occurs no earlier than the cycle after DONE, and the second request's data is correct.
- Reset mid-burst:
  - Assert reset during beat 2 of an MLEN4 read: the next cycle has cresp = '0, busy = 0, state IDLE.
  - A new MLEN4 read after deassertion completes with correct data.
- Aliasing and address wrap:
  - MEM_WORDS 4096; write 0x5A to addr 0x0000_4000; read addr 0x0000_0000 returns 0x5A.
  - An MLEN16 read starting at word 15 returns words 15, 0, 1, …, 14 of that block.
